// File: rtl/kfpga_config_pkg.sv
// Shared definitions for the configuration loader and the IO tiles it feeds.
package kfpga_config_pkg;

  // Loader FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } config_state_e;

  // IO tile configuration field offsets within one tile's slice of config_out.
  localparam int unsigned TileCfgWidth = 4;
  localparam int unsigned MuxIc0Off    = 0;
  localparam int unsigned MuxIc1Off    = 1;
  localparam int unsigned MuxIo0Off    = 2;
  localparam int unsigned MuxIo1Off    = 3;

  // Ceiling of log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r++;
    end
    return r;
  endfunction

  // Integer division rounded up.
  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/config_loader.sv
// Loads the configuration bitstream word by word into a shadow register and
// commits it to config_out atomically once the final word has arrived.
module config_loader
  import kfpga_config_pkg::*;
#(
  parameter int unsigned CONFIG_WIDTH = 16,
  parameter int unsigned WORD_WIDTH   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    config_start,
  input  logic [WORD_WIDTH-1:0]   data_in,
  input  logic                    data_in_valid,
  output logic                    data_in_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_loaded,
  output logic                    config_busy
);

  localparam int unsigned NumWords = ceil_div(CONFIG_WIDTH, WORD_WIDTH);
  localparam int unsigned CntW     = clog2(NumWords + 1);
  localparam int unsigned ShadowW  = NumWords * WORD_WIDTH;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumWords - 1);

  config_state_e         state_q, state_d;
  logic [ShadowW-1:0]    shadow_q, shadow_d;
  logic [CntW-1:0]       word_count_q, word_count_d;
  logic [CONFIG_WIDTH-1:0] config_out_q, config_out_d;
  logic                  loaded_q, loaded_d;
  logic                  ready_q;
  logic                  accept;

  assign accept        = data_in_valid && ready_q;
  assign data_in_ready = ready_q;
  assign config_busy   = ready_q;
  assign config_out    = config_out_q;
  assign config_loaded = loaded_q;

  // Next-state: FSM, shadow fill, word counter and commit.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    word_count_d = word_count_q;
    config_out_d = config_out_q;
    loaded_d     = loaded_q;
    unique case (state_q)
      StIdle: begin
        if (config_start) begin
          state_d      = StLoad;
          shadow_d     = '0;
          word_count_d = '0;
        end
      end
      StLoad: begin
        // A restart wins over a word accepted in the same cycle.
        if (config_start) begin
          shadow_d     = '0;
          word_count_d = '0;
        end else if (accept) begin
          for (int unsigned w = 0; w < NumWords; w++) begin
            if (word_count_q == CntW'(w)) begin
              shadow_d[w*WORD_WIDTH +: WORD_WIDTH] = data_in;
            end
          end
          word_count_d = word_count_q + 1'b1;
          if (word_count_q == LastCnt) begin
            // Bits beyond CONFIG_WIDTH in the final word are dropped here.
            config_out_d = shadow_d[CONFIG_WIDTH-1:0];
            loaded_d     = 1'b1;
            state_d      = StDone;
          end
        end
      end
      StDone: begin
        if (config_start) begin
          state_d      = StLoad;
          loaded_d     = 1'b0;
          shadow_d     = '0;
          word_count_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; ready/busy registered from next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      shadow_q     <= '0;
      word_count_q <= '0;
      config_out_q <= '0;
      loaded_q     <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      word_count_q <= word_count_d;
      config_out_q <= config_out_d;
      loaded_q     <= loaded_d;
      ready_q      <= (state_d == StLoad);
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: a 16/4 instance and a 6/4 instance share stimulus and
// are compared every cycle against a word-assembly reference model.
module tb_config_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        config_start = 1'b0;
  logic [3:0]  data_in = 4'h0;
  logic        data_in_valid = 1'b0;

  logic        rdy_a, ld_a, busy_a;
  logic [15:0] out_a;
  logic        rdy_b, ld_b, busy_b;
  logic [5:0]  out_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference model per instance: phase 0 idle, 1 loading, 2 done.
  int          m_phase [2];
  int          m_cnt   [2];
  logic [31:0] m_acc   [2];
  logic [15:0] m_out   [2];
  logic        m_ld    [2];

  always #5 clock = ~clock;

  config_loader #(.CONFIG_WIDTH(16), .WORD_WIDTH(4)) dut_a (
    .clock(clock), .reset(reset), .config_start(config_start), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_in_ready(rdy_a), .config_out(out_a),
    .config_loaded(ld_a), .config_busy(busy_a)
  );

  config_loader #(.CONFIG_WIDTH(6), .WORD_WIDTH(4)) dut_b (
    .clock(clock), .reset(reset), .config_start(config_start), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_in_ready(rdy_b), .config_out(out_b),
    .config_loaded(ld_b), .config_busy(busy_b)
  );

  function automatic void model_edge(input logic r, input logic st, input logic v,
                                     input logic [3:0] d);
    for (int i = 0; i < 2; i++) begin
      int nw;
      int cw;
      nw = (i == 0) ? 4 : 2;
      cw = (i == 0) ? 16 : 6;
      if (r) begin
        m_phase[i] = 0; m_cnt[i] = 0; m_acc[i] = '0; m_out[i] = '0; m_ld[i] = 1'b0;
      end else if (m_phase[i] == 0) begin
        if (st) begin m_phase[i] = 1; m_cnt[i] = 0; m_acc[i] = '0; end
      end else if (m_phase[i] == 1) begin
        if (st) begin
          m_cnt[i] = 0; m_acc[i] = '0;
        end else if (v) begin
          m_acc[i] = m_acc[i] | (32'(d) << (4 * m_cnt[i]));
          m_cnt[i]++;
          if (m_cnt[i] == nw) begin
            m_out[i]   = 16'(m_acc[i] & ((32'd1 << cw) - 32'd1));
            m_ld[i]    = 1'b1;
            m_phase[i] = 2;
          end
        end
      end else begin
        if (st) begin m_phase[i] = 1; m_ld[i] = 1'b0; m_cnt[i] = 0; m_acc[i] = '0; end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then check both instances.
  task automatic step(input logic r, input logic st, input logic v, input logic [3:0] d);
    reset = r; config_start = st; data_in_valid = v; data_in = d;
    @(posedge clock);
    model_edge(r, st, v, d);
    #1;
    chk("a_out",   out_a,            m_out[0]);
    chk("a_ld",    16'(ld_a),        16'(m_ld[0]));
    chk("a_ready", 16'(rdy_a),       16'(m_phase[0] == 1));
    chk("a_busy",  16'(busy_a),      16'(m_phase[0] == 1));
    chk("b_out",   {10'b0, out_b},   m_out[1]);
    chk("b_ld",    16'(ld_b),        16'(m_ld[1]));
    chk("b_ready", 16'(rdy_b),       16'(m_phase[1] == 1));
    chk("b_busy",  16'(busy_b),      16'(m_phase[1] == 1));
  endtask

  initial begin
    logic [6:0] pat;
    logic [3:0] wd [4];
    int         k;

    // Reset, then a back-to-back load of 1,2,3,4.
    step(1, 0, 0, 4'h0);
    step(1, 1, 1, 4'hF);
    step(0, 0, 1, 4'hF);
    step(0, 1, 0, 4'h0);
    step(0, 0, 1, 4'h1);
    step(0, 0, 1, 4'h2);
    step(0, 0, 1, 4'h3);
    step(0, 0, 1, 4'h4);
    chk("a_first_load", out_a, 16'h4321);
    step(0, 0, 0, 4'h0);

    // Same words with gaps: valid pattern 1,0,0,1,0,1,1.
    pat = 7'b1101001;
    wd[0] = 4'h1; wd[1] = 4'h2; wd[2] = 4'h3; wd[3] = 4'h4;
    k = 0;
    step(0, 1, 0, 4'h0);
    for (int i = 0; i < 7; i++) begin
      if (pat[i]) begin step(0, 0, 1, wd[k]); k++; end
      else step(0, 0, 0, 4'hE);
    end
    chk("a_gap_load", out_a, 16'h4321);
    chk("a_gap_ld", 16'(ld_a), 16'h1);

    // DONE without start ignores valid words.
    for (int i = 0; i < 10; i++) step(0, 0, 1, 4'hF);
    chk("a_done_hold", out_a, 16'h4321);

    // Narrow instance: 0xF,0xF commits 0x3F after the second accept.
    step(0, 1, 0, 4'h0);
    step(0, 0, 1, 4'hF);
    step(0, 0, 1, 4'hF);
    chk("b_trunc", {10'b0, out_b}, 16'h003F);
    step(0, 0, 1, 4'hF);
    step(0, 0, 1, 4'hF);
    chk("a_ffff", out_a, 16'hFFFF);

    // Restart mid-load with a word in the restart cycle.
    step(0, 0, 1, 4'h0);
    step(0, 1, 0, 4'h0);
    step(0, 0, 1, 4'hA);
    step(0, 0, 1, 4'hB);
    step(0, 1, 1, 4'hC);
    chk("a_restart_hold", out_a, 16'hFFFF);
    step(0, 0, 1, 4'h5);
    step(0, 0, 1, 4'h6);
    step(0, 0, 1, 4'h7);
    chk("a_not_loaded", 16'(ld_a), 16'h0);
    step(0, 0, 1, 4'h8);
    chk("a_restart_load", out_a, 16'h8765);

    // Reset during a load, idle with valid words, then a normal load.
    step(0, 1, 0, 4'h0);
    step(0, 0, 1, 4'h9);
    step(0, 0, 1, 4'h9);
    step(1, 0, 1, 4'h9);
    chk("a_reset_out", out_a, 16'h0000);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 4'hF);
    step(0, 1, 0, 4'h0);
    step(0, 0, 1, 4'hD);
    step(0, 0, 1, 4'hE);
    step(0, 0, 1, 4'hA);
    step(0, 0, 1, 4'hD);
    chk("a_after_reset", out_a, 16'hDAED);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 6),
           ($urandom_range(0, 99) < 60), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
